// File: rtl/core_bus_pkg.sv
// rtl/core_bus_pkg.sv - opcodes, error codes and FSM states shared by the bus scheduler
package core_bus_pkg;

  localparam logic [7:0] OP_NOP    = 8'h00;
  localparam logic [7:0] OP_WRITE  = 8'h01;
  localparam logic [7:0] OP_READ   = 8'h02;
  localparam logic [7:0] OP_START  = 8'h03;
  localparam logic [7:0] OP_STATUS = 8'h04;

  localparam logic [31:0] ERR_TIMEOUT = 32'hDEAD_0001;
  localparam logic [31:0] ERR_BAD_ID  = 32'hDEAD_0002;
  localparam logic [31:0] ERR_BAD_OP  = 32'hDEAD_0003;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_CHECK,
    ST_ISSUE,
    ST_DONE
  } state_e;

  function automatic logic is_known_op(input logic [7:0] op);
    return op inside {OP_WRITE, OP_READ, OP_START, OP_STATUS};
  endfunction

endpackage

// File: rtl/bus_timeout_counter.sv
// rtl/bus_timeout_counter.sv - ack wait counter; expired fires in the cycle the count would reach the limit
module bus_timeout_counter #(
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic clear_i,
  input  logic enable_i,
  output logic expired_o
);

  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);

  logic [CW-1:0] count_q;
  logic [CW-1:0] count_d;

  // Combinational expiry lets the FSM leave after exactly TIMEOUT_CYCLES waiting cycles.
  assign expired_o = enable_i && (count_q == CW'(TIMEOUT_CYCLES - 1));

  always_comb begin
    count_d = count_q;
    if (clear_i) begin
      count_d = '0;
    end else if (enable_i && !expired_o) begin
      count_d = count_q + CW'(1);
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

endmodule

// File: rtl/core_bus_scheduler.sv
// rtl/core_bus_scheduler.sv - issues one decoded command at a time to a selected core and returns its result
module core_bus_scheduler
  import core_bus_pkg::*;
#(
  parameter int NUM_CORES      = 4,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic                      sys_clock_i,
  input  logic                      sys_reset_i,
  input  logic                      instr_valid_i,
  input  logic [7:0]                instruction_i,
  input  logic [23:0]               address_i,
  input  logic [31:0]               value_i,
  output logic                      core_req_o,
  output logic [NUM_CORES-1:0]      core_sel_o,
  output logic [7:0]                core_instr_o,
  output logic [15:0]               core_addr_o,
  output logic [31:0]               core_value_o,
  input  logic [NUM_CORES-1:0]      core_ack_i,
  input  logic [NUM_CORES*32-1:0]   core_result_i,
  output logic [31:0]               result_o,
  output logic                      result_valid_o,
  output logic                      busy_o,
  output logic                      error_o,
  output logic                      overrun_o
);

  state_e                 state_q, state_d;
  logic [7:0]             instr_q, instr_d;
  logic [23:0]            addr_q, addr_d;
  logic [31:0]            value_q, value_d;
  logic [31:0]            result_q, result_d;
  logic                   result_valid_q, result_valid_d;
  logic                   core_req_q, core_req_d;
  logic [NUM_CORES-1:0]   core_sel_q, core_sel_d;
  logic                   busy_q, busy_d;
  logic                   error_q, error_d;
  logic                   overrun_q, overrun_d;
  logic                   timeout_seen_q, timeout_seen_d;

  logic                   timer_clear;
  logic                   timer_enable;
  logic                   timer_expired;
  logic                   ack_hit;
  logic [31:0]            ack_word;
  logic [NUM_CORES-1:0]   sel_dec;
  logic                   bad_id;

  assign bad_id = ({1'b0, addr_q[23:16]} >= 9'(NUM_CORES));

  always_comb begin
    sel_dec = '0;
    for (int i = 0; i < NUM_CORES; i++) begin
      if (addr_q[23:16] == 8'(i)) begin
        sel_dec[i] = 1'b1;
      end
    end
  end

  // Masking with the registered select makes acks from other cores invisible.
  assign ack_hit = |(core_ack_i & core_sel_q);

  always_comb begin
    ack_word = '0;
    for (int i = 0; i < NUM_CORES; i++) begin
      if (core_sel_q[i]) begin
        ack_word = core_result_i[32*i +: 32];
      end
    end
  end

  assign timer_enable = (state_q == ST_ISSUE) && !ack_hit;

  bus_timeout_counter #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_timeout (
    .clk_i     (sys_clock_i),
    .rst_i     (sys_reset_i),
    .clear_i   (timer_clear),
    .enable_i  (timer_enable),
    .expired_o (timer_expired)
  );

  always_comb begin
    state_d        = state_q;
    instr_d        = instr_q;
    addr_d         = addr_q;
    value_d        = value_q;
    result_d       = result_q;
    error_d        = error_q;
    overrun_d      = overrun_q;
    timeout_seen_d = timeout_seen_q;
    core_sel_d     = '0;
    timer_clear    = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (instr_valid_i && (instruction_i != OP_NOP)) begin
          instr_d = instruction_i;
          addr_d  = address_i;
          value_d = value_i;
          state_d = ST_CHECK;
        end
      end
      ST_CHECK: begin
        if (bad_id) begin
          result_d = ERR_BAD_ID;
          error_d  = 1'b1;
          state_d  = ST_DONE;
        end else if (!is_known_op(instr_q)) begin
          result_d = ERR_BAD_OP;
          error_d  = 1'b1;
          state_d  = ST_DONE;
        end else if (instr_q == OP_STATUS) begin
          result_d = {29'b0, overrun_q, error_q, timeout_seen_q};
          state_d  = ST_DONE;
        end else begin
          core_sel_d  = sel_dec;
          timer_clear = 1'b1;
          state_d     = ST_ISSUE;
        end
      end
      ST_ISSUE: begin
        if (ack_hit) begin
          result_d = ack_word;
          state_d  = ST_DONE;
        end else if (timer_expired) begin
          result_d       = ERR_TIMEOUT;
          error_d        = 1'b1;
          timeout_seen_d = 1'b1;
          state_d        = ST_DONE;
        end else begin
          core_sel_d = core_sel_q;
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    if ((state_q != ST_IDLE) && instr_valid_i) begin
      overrun_d = 1'b1;
    end

    core_req_d     = (state_d == ST_ISSUE);
    result_valid_d = (state_d == ST_DONE);
    busy_d         = (state_d != ST_IDLE);
  end

  always_ff @(posedge sys_clock_i) begin
    if (sys_reset_i) begin
      state_q        <= ST_IDLE;
      instr_q        <= '0;
      addr_q         <= '0;
      value_q        <= '0;
      result_q       <= '0;
      result_valid_q <= 1'b0;
      core_req_q     <= 1'b0;
      core_sel_q     <= '0;
      busy_q         <= 1'b0;
      error_q        <= 1'b0;
      overrun_q      <= 1'b0;
      timeout_seen_q <= 1'b0;
    end else begin
      state_q        <= state_d;
      instr_q        <= instr_d;
      addr_q         <= addr_d;
      value_q        <= value_d;
      result_q       <= result_d;
      result_valid_q <= result_valid_d;
      core_req_q     <= core_req_d;
      core_sel_q     <= core_sel_d;
      busy_q         <= busy_d;
      error_q        <= error_d;
      overrun_q      <= overrun_d;
      timeout_seen_q <= timeout_seen_d;
    end
  end

  assign core_req_o     = core_req_q;
  assign core_sel_o     = core_sel_q;
  assign core_instr_o   = instr_q;
  assign core_addr_o    = addr_q[15:0];
  assign core_value_o   = value_q;
  assign result_o       = result_q;
  assign result_valid_o = result_valid_q;
  assign busy_o         = busy_q;
  assign error_o        = error_q;
  assign overrun_o      = overrun_q;

endmodule

// File: tb/tb_core_bus_scheduler.sv
// tb/tb_core_bus_scheduler.sv - directed self-checking bench for core_bus_scheduler
module tb_core_bus_scheduler;

  localparam int NC = 4;

  logic            clk = 1'b0;
  logic            rst;
  logic            instr_valid;
  logic [7:0]      instruction;
  logic [23:0]     address;
  logic [31:0]     value;
  logic            core_req;
  logic [NC-1:0]   core_sel;
  logic [7:0]      core_instr;
  logic [15:0]     core_addr;
  logic [31:0]     core_value;
  logic [NC-1:0]   core_ack;
  logic [NC*32-1:0] core_result;
  logic [31:0]     result;
  logic            result_valid;
  logic            busy;
  logic            error;
  logic            overrun;

  int n_checks = 0;
  int n_fail   = 0;
  int req_cycles;

  core_bus_scheduler #(
    .NUM_CORES(NC),
    .TIMEOUT_CYCLES(255)
  ) dut (
    .sys_clock_i    (clk),
    .sys_reset_i    (rst),
    .instr_valid_i  (instr_valid),
    .instruction_i  (instruction),
    .address_i      (address),
    .value_i        (value),
    .core_req_o     (core_req),
    .core_sel_o     (core_sel),
    .core_instr_o   (core_instr),
    .core_addr_o    (core_addr),
    .core_value_o   (core_value),
    .core_ack_i     (core_ack),
    .core_result_i  (core_result),
    .result_o       (result),
    .result_valid_o (result_valid),
    .busy_o         (busy),
    .error_o        (error),
    .overrun_o      (overrun)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic send(input logic [7:0] op, input logic [23:0] addr, input logic [31:0] val);
    instruction = op;
    address     = addr;
    value       = val;
    instr_valid = 1'b1;
    @(negedge clk);
    instr_valid = 1'b0;
  endtask

  task automatic wait_done(output int reqs);
    int n;
    n    = 0;
    reqs = 0;
    while (!result_valid && n < 600) begin
      if (core_req) reqs++;
      @(negedge clk);
      n++;
    end
    if (!result_valid) check_eq("wait_done_bound", {31'b0, result_valid}, 32'd1);
  endtask

  task automatic check_all_zero(input string tag);
    check_eq({tag, "_req"},   {31'b0, core_req}, 32'd0);
    check_eq({tag, "_sel"},   {28'b0, core_sel}, 32'd0);
    check_eq({tag, "_instr"}, {24'b0, core_instr}, 32'd0);
    check_eq({tag, "_addr"},  {16'b0, core_addr}, 32'd0);
    check_eq({tag, "_value"}, core_value, 32'd0);
    check_eq({tag, "_result"}, result, 32'd0);
    check_eq({tag, "_rvalid"}, {31'b0, result_valid}, 32'd0);
    check_eq({tag, "_busy"},  {31'b0, busy}, 32'd0);
    check_eq({tag, "_error"}, {31'b0, error}, 32'd0);
    check_eq({tag, "_overrun"}, {31'b0, overrun}, 32'd0);
  endtask

  initial begin
    rst = 1'b1;
    instr_valid = 1'b0;
    instruction = '0;
    address = '0;
    value = '0;
    core_ack = '0;
    core_result = '0;
    @(negedge clk);
    do_reset();
    check_all_zero("reset");

    // NOP is ignored
    send(8'h00, 24'h000000, 32'h0);
    check_eq("nop_busy", {31'b0, busy}, 32'd0);

    // STATUS from clean state
    send(8'h04, 24'h000000, 32'h0);
    @(negedge clk);
    check_eq("status0_valid", {31'b0, result_valid}, 32'd1);
    check_eq("status0_result", result, 32'h0000_0000);

    // READ core 1, ack after 5 waiting cycles
    core_result[32*1 +: 32] = 32'h1234_5678;
    @(negedge clk);
    send(8'h02, 24'h01_0010, 32'h0000_00AA);
    check_eq("rd_busy_check", {31'b0, busy}, 32'd1);
    check_eq("rd_req_check", {31'b0, core_req}, 32'd0);
    @(negedge clk);
    check_eq("rd_req", {31'b0, core_req}, 32'd1);
    check_eq("rd_sel", {28'b0, core_sel}, 32'h2);
    check_eq("rd_instr", {24'b0, core_instr}, 32'h02);
    check_eq("rd_addr", {16'b0, core_addr}, 32'h0010);
    check_eq("rd_value", core_value, 32'h0000_00AA);
    repeat (5) @(negedge clk);
    check_eq("rd_req_held", {31'b0, core_req}, 32'd1);
    core_ack = 4'b0010;
    @(negedge clk);
    core_ack = '0;
    check_eq("rd_valid", {31'b0, result_valid}, 32'd1);
    check_eq("rd_result", result, 32'h1234_5678);
    check_eq("rd_error", {31'b0, error}, 32'd0);
    check_eq("rd_req_drop", {31'b0, core_req}, 32'd0);
    @(negedge clk);
    check_eq("rd_valid_pulse", {31'b0, result_valid}, 32'd0);
    check_eq("rd_result_hold", result, 32'h1234_5678);
    check_eq("rd_idle", {31'b0, busy}, 32'd0);

    // WRITE to nonexistent core 7
    send(8'h01, 24'h07_0000, 32'h5);
    @(negedge clk);
    check_eq("badid_valid", {31'b0, result_valid}, 32'd1);
    check_eq("badid_req", {31'b0, core_req}, 32'd0);
    check_eq("badid_result", result, 32'hDEAD_0002);
    check_eq("badid_error", {31'b0, error}, 32'd1);
    @(negedge clk);

    // Unknown opcode
    send(8'h07, 24'h00_0000, 32'h0);
    @(negedge clk);
    check_eq("badop_result", result, 32'hDEAD_0003);
    check_eq("badop_req", {31'b0, core_req}, 32'd0);
    @(negedge clk);

    // START to core 0, never acked
    do_reset();
    send(8'h03, 24'h00_0040, 32'h1);
    wait_done(req_cycles);
    check_eq("to_req_cycles", req_cycles, 32'd255);
    check_eq("to_result", result, 32'hDEAD_0001);
    check_eq("to_error", {31'b0, error}, 32'd1);
    @(negedge clk);
    send(8'h04, 24'h00_0000, 32'h0);
    @(negedge clk);
    check_eq("to_status", result, 32'h0000_0003);
    @(negedge clk);

    // Overrun during ISSUE
    do_reset();
    core_result[32*2 +: 32] = 32'hCAFE_F00D;
    send(8'h02, 24'h02_0005, 32'h0);
    @(negedge clk);
    instruction = 8'h01;
    address = 24'h03_0009;
    value = 32'h7777_7777;
    instr_valid = 1'b1;
    @(negedge clk);
    instr_valid = 1'b0;
    check_eq("ovr_flag", {31'b0, overrun}, 32'd1);
    check_eq("ovr_sel_kept", {28'b0, core_sel}, 32'h4);
    check_eq("ovr_instr_kept", {24'b0, core_instr}, 32'h02);
    check_eq("ovr_addr_kept", {16'b0, core_addr}, 32'h0005);
    core_ack = 4'b0100;
    @(negedge clk);
    core_ack = '0;
    wait_done(req_cycles);
    check_eq("ovr_result", result, 32'hCAFE_F00D);
    check_eq("ovr_error", {31'b0, error}, 32'd0);
    req_cycles = 0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      if (core_req || busy) req_cycles++;
    end
    check_eq("ovr_no_second", req_cycles, 32'd0);

    // Reset mid-ISSUE, then a minimum-latency command
    send(8'h02, 24'h01_0020, 32'h9);
    @(negedge clk);
    check_eq("rst_mid_req", {31'b0, core_req}, 32'd1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check_all_zero("rst_mid");
    core_result[32*3 +: 32] = 32'h0BAD_BEEF;
    send(8'h02, 24'h03_0001, 32'h0);
    @(negedge clk);
    core_ack = 4'b1000;
    @(negedge clk);
    core_ack = '0;
    check_eq("fast_valid", {31'b0, result_valid}, 32'd1);
    check_eq("fast_result", result, 32'h0BAD_BEEF);
    @(negedge clk);

    // Foreign ack ignored
    core_result[32*2 +: 32] = 32'h2222_2222;
    core_result[32*0 +: 32] = 32'h0000_0011;
    send(8'h02, 24'h00_0003, 32'h0);
    @(negedge clk);
    core_ack = 4'b0100;
    @(negedge clk);
    check_eq("foreign_valid", {31'b0, result_valid}, 32'd0);
    check_eq("foreign_req", {31'b0, core_req}, 32'd1);
    core_ack = 4'b0001;
    @(negedge clk);
    core_ack = '0;
    check_eq("own_valid", {31'b0, result_valid}, 32'd1);
    check_eq("own_result", result, 32'h0000_0011);
    @(negedge clk);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
